rgb_sram_writer: RTL and testbench
==================================

// Module: rgb_sram_writer
// PURPOSE
//  Downstream stage of the YUV->RGB colourspace converter. Accepts converted pixel pairs
//  (R0,G0,B0,R1,G1,B1) over a valid/ready handshake and buffers them in a small FIFO.
//  Packs each pair into three 16-bit words {R0,G0},{B0,R1},{G1,B1} and writes them to SRAM
//  at RGB_START + 3*pair_index under a req/grant arbitration, one word per granted cycle.
//  Signals Stop when one full frame (320x240) has been written.
// PARAMETERS
//  RGB_START    18'd146944  SRAM word address of the first RGB word
//  FRAME_PAIRS  17'd38400   pixel pairs per frame (320*240/2)
//  FIFO_DEPTH   4           pair-FIFO depth in entries; power of 2, >=2
// PORTS
//  Clock            in   1   system clock, all logic on rising edge
//  Reset            in   1   synchronous, active-high reset
//  Start            in   1   1-cycle pulse; begins a frame (honoured only in IDLE or DONE)
//  Stop             out  1   high in DONE; cleared by Start or Reset
//  pix_valid        in   1   pix_data holds a valid pair
//  pix_ready        out  1   FIFO can accept (not full, state != IDLE/DONE)
//  pix_data         in   48  {R0,G0,B0,R1,G1,B1}, 8 b unsigned each, MSB first
//  sram_req         out  1   writer requests SRAM ownership
//  sram_grant       in   1   arbiter grant; may drop on any cycle
//  SRAM_address     out  18  registered word address
//  SRAM_write_data  out  16  registered write data
//  SRAM_we_n        out  1   registered active-low write enable
// BEHAVIOUR
//  Reset: state IDLE; Stop=0, pix_ready=0, sram_req=0, SRAM_address=0,
//   SRAM_write_data=0, SRAM_we_n=1; FIFO emptied; pair_cnt=0, word_sel=0. Reset wins over all.
//  FSM: IDLE -Start-> RUN; RUN -(last word of pair FRAME_PAIRS-1 written)-> DONE;
//   DONE -Start-> RUN. Start in RUN is ignored.
//  Accept: pair pushed when pix_valid & pix_ready; pix_ready is a registered function of
//   occupancy (deasserts the cycle after the FIFO becomes full, i.e. leaves one slot margin
//   only if registered-full logic requires it; no pair is ever dropped or overwritten).
//  Write: in RUN, sram_req=1 whenever FIFO non-empty. On an edge where state=RUN, FIFO
//   non-empty and sram_grant=1: SRAM_address<=RGB_START+3*pair_cnt+word_sel,
//   SRAM_write_data<=word[word_sel], SRAM_we_n<=0, word_sel advances 0->1->2->0.
//   After word 2: FIFO head popped, pair_cnt++. Otherwise SRAM_we_n<=1, address/data hold.
//  Latency: pair accepted at edge t, grant held -> word0 on SRAM pins after edge t+1,
//   word1 after t+2, word2 after t+3. Sustained throughput 1 pair / 3 granted cycles.
//  Grant loss mid-pair: write suspends, word_sel held; resumes at same word on regrant.
//  Simultaneous push+pop with FIFO full: push allowed only if pix_ready was high; occupancy
//   unchanged.
//  Address arithmetic: 18 b unsigned; last word = RGB_START+3*FRAME_PAIRS-1 = 18'h3FFFF;
//   no wrap permitted; pair_cnt 17 b.
//  On entry to DONE: sram_req=0, SRAM_we_n=1, Stop=1; on Start: pair_cnt, word_sel cleared.
//  Reset mid-frame: all writing stops next edge; partially written pair is abandoned.
// CONFIGURATION
//  RGB_WR_STATS_EN defined: adds outputs stall_cycles[23:0] (RUN & FIFO non-empty &
//   ~sram_grant) and underrun_cycles[23:0] (RUN & FIFO empty); both cleared on Reset and
//   on Start, saturate at all-ones.
//  Undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  Package rgb_wr_pkg: RGB_START, FRAME_PAIRS, IMG_WIDTH=320, IMG_HEIGHT=240,
//   typedef rgb_pair_t (packed 6x8 b), typedef enum {S_IDLE,S_RUN,S_DONE} rgb_wr_state_t.
//  Sub-module rgb_pair_fifo: synchronous FIFO of rgb_pair_t, FIFO_DEPTH entries,
//   full/empty flags, push/pop same cycle legal. Top keeps FSM, packer, address gen.
// TESTING
//  1 Start, grant=1, one pair {10,20,30,40,50,60} -> writes 146944:0x0A14, 146945:0x1E28,
//    146946:0x323C on 3 consecutive edges, we_n=1 afterwards.
//  2 Grant dropped for 5 cycles after word0 -> no we_n pulse during gap; word1,word2 then
//    written at 146945,146946; no duplicate or skipped address.
//  3 Grant=0, stream pairs continuously -> pix_ready low after FIFO_DEPTH accepts, no loss;
//    grant=1 -> all pairs written in order.
//  4 Full frame, random valid/grant -> 115200 writes, last at 18'h3FFFF, Stop=1, then
//    sram_req=0; second Start restarts at 146944.
//  5 Reset asserted mid-pair -> next edge we_n=1, Stop=0, state IDLE, FIFO empty.
//  6 RGB_WR_STATS_EN: 7 grant-off cycles with data pending -> stall_cycles=7.

Source files
------------

// File: rtl/rgb_wr_pkg.sv
// Shared frame constants, pixel-pair type and FSM states for the RGB SRAM writer.
package rgb_wr_pkg;

   localparam int unsigned IMG_WIDTH   = 320;
   localparam int unsigned IMG_HEIGHT  = 240;
   localparam logic [17:0] RGB_START   = 18'd146944;
   localparam logic [16:0] FRAME_PAIRS = 17'(IMG_WIDTH * IMG_HEIGHT / 2);

   typedef struct packed {
      logic [7:0] r0;
      logic [7:0] g0;
      logic [7:0] b0;
      logic [7:0] r1;
      logic [7:0] g1;
      logic [7:0] b1;
   } rgb_pair_t;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} rgb_wr_state_t;

   // Word sel of a pair: 0 -> {R0,G0}, 1 -> {B0,R1}, 2 -> {G1,B1}.
   function automatic logic [15:0] pair_word(input rgb_pair_t p, input logic [1:0] sel);
      logic [15:0] w;
      case (sel)
         2'd0:    w = {p.r0, p.g0};
         2'd1:    w = {p.b0, p.r1};
         default: w = {p.g1, p.b1};
      endcase
      return w;
   endfunction

endpackage

// File: rtl/rgb_sram_writer_if.sv
// Pixel-pair handshake and SRAM write bus between the converter, writer and arbiter.
interface rgb_sram_writer_if;
   import rgb_wr_pkg::*;

   logic        pix_valid;
   logic        pix_ready;
   rgb_pair_t   pix_data;
   logic        sram_req;
   logic        sram_grant;
   logic [17:0] SRAM_address;
   logic [15:0] SRAM_write_data;
   logic        SRAM_we_n;

   modport master (
      input  pix_valid, pix_data, sram_grant,
      output pix_ready, sram_req, SRAM_address, SRAM_write_data, SRAM_we_n
   );

   modport slave (
      output pix_valid, pix_data, sram_grant,
      input  pix_ready, sram_req, SRAM_address, SRAM_write_data, SRAM_we_n
   );
endinterface

// File: rtl/rgb_pair_fifo.sv
// Synchronous FIFO of pixel pairs; push and pop in the same cycle are legal.
module rgb_pair_fifo
   import rgb_wr_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     Clock,
   input  logic                     Reset,
   input  logic                     push,
   input  rgb_pair_t                din,
   input  logic                     pop,
   output rgb_pair_t                dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   rgb_pair_t   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] cnt_q;
   logic          do_push, do_pop;

   assign full    = (cnt_q == CW'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem_q[rd_ptr_q];
   assign count   = cnt_q;

   always_ff @(posedge Clock) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/rgb_sram_writer.sv
// Packs converted RGB pixel pairs into three 16-bit words each and writes one frame to SRAM.
// Defining RGB_WR_STATS_EN adds stall_cycles/underrun_cycles counter outputs.
module rgb_sram_writer
   import rgb_wr_pkg::*;
#(
   parameter logic [17:0] RGB_START   = rgb_wr_pkg::RGB_START,
   parameter logic [16:0] FRAME_PAIRS = rgb_wr_pkg::FRAME_PAIRS,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  Start,
   output logic                  Stop,
   rgb_sram_writer_if.master     bus
`ifdef RGB_WR_STATS_EN
   ,
   output logic [23:0]           stall_cycles,
   output logic [23:0]           underrun_cycles
`endif
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   rgb_wr_state_t state_q, state_d;
   logic [16:0]   pair_cnt_q, pair_cnt_d;
   logic [1:0]    word_sel_q, word_sel_d;
   logic [17:0]   addr_q, addr_d;
   logic [15:0]   data_q, data_d;
   logic          we_n_q, we_n_d;
   logic          pix_ready_q, pix_ready_d;
   logic          push, pop, wr_go;
   logic          fifo_full, fifo_empty;
   logic [CW-1:0] fifo_count;
   rgb_pair_t     head;

   assign push  = bus.pix_valid & pix_ready_q;
   assign wr_go = (state_q == S_RUN) & ~fifo_empty & bus.sram_grant;

   rgb_pair_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .Clock (Clock),
      .Reset (Reset),
      .push  (push),
      .din   (bus.pix_data),
      .pop   (pop),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_comb begin
      state_d    = state_q;
      pair_cnt_d = pair_cnt_q;
      word_sel_d = word_sel_q;
      addr_d     = addr_q;
      data_d     = data_q;
      we_n_d     = 1'b1;
      pop        = 1'b0;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (Start) begin
               state_d    = S_RUN;
               pair_cnt_d = '0;
               word_sel_d = '0;
            end
         end
         S_RUN: begin
            if (wr_go) begin
               addr_d = RGB_START + 18'(pair_cnt_q) * 18'd3 + 18'(word_sel_q);
               data_d = pair_word(head, word_sel_q);
               we_n_d = 1'b0;
               if (word_sel_q == 2'd2) begin
                  word_sel_d = '0;
                  pop        = 1'b1;
                  pair_cnt_d = pair_cnt_q + 17'd1;
                  if (pair_cnt_q == FRAME_PAIRS - 17'd1) state_d = S_DONE;
               end else begin
                  word_sel_d = word_sel_q + 2'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Ready is registered, so it must fall on the same edge the FIFO becomes full.
      pix_ready_d = (state_d == S_RUN) &&
                    !((fifo_full && !pop) ||
                      (fifo_count == CW'(FIFO_DEPTH - 1) && push && !pop));
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q     <= S_IDLE;
         pair_cnt_q  <= '0;
         word_sel_q  <= '0;
         addr_q      <= '0;
         data_q      <= '0;
         we_n_q      <= 1'b1;
         pix_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pair_cnt_q  <= pair_cnt_d;
         word_sel_q  <= word_sel_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         we_n_q      <= we_n_d;
         pix_ready_q <= pix_ready_d;
      end
   end

   assign Stop                = (state_q == S_DONE);
   assign bus.pix_ready       = pix_ready_q;
   assign bus.sram_req        = (state_q == S_RUN) & ~fifo_empty;
   assign bus.SRAM_address    = addr_q;
   assign bus.SRAM_write_data = data_q;
   assign bus.SRAM_we_n       = we_n_q;

`ifdef RGB_WR_STATS_EN
   logic start_go;
   assign start_go = Start & (state_q != S_RUN);

   always_ff @(posedge Clock) begin
      if (Reset || start_go) begin
         stall_cycles    <= '0;
         underrun_cycles <= '0;
      end else if (state_q == S_RUN) begin
         if (!fifo_empty && !bus.sram_grant && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + 24'd1;
         end
         if (fifo_empty && underrun_cycles != '1) begin
            underrun_cycles <= underrun_cycles + 24'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_rgb_sram_writer.sv
// Self-checking bench for rgb_sram_writer; a second instance placed at the top of the address
// space shares the stimulus so the last-word boundary (18'h3FFFF) is exercised on a short frame.
module tb_rgb_sram_writer;

   localparam int          FP       = 16;
   localparam int          DEPTH    = 4;
   localparam logic [17:0] START_A  = 18'd146944;
   localparam logic [17:0] START_E  = 18'h3FFFF - 18'(3 * FP) + 18'd1;

   typedef struct packed {
      logic [47:0] pix;
      logic [15:0] w0;
      logic [15:0] w1;
      logic [15:0] w2;
   } vec_t;

   logic Clock = 1'b0;
   logic Reset, Start, stop, stop_e;

   rgb_sram_writer_if bus ();
   rgb_sram_writer_if bus_e ();

   assign bus_e.pix_valid  = bus.pix_valid;
   assign bus_e.pix_data   = bus.pix_data;
   assign bus_e.sram_grant = bus.sram_grant;

`ifdef RGB_WR_STATS_EN
   logic [23:0] stall, underrun, stall_e, underrun_e;
`endif

   rgb_sram_writer #(
      .RGB_START   (START_A),
      .FRAME_PAIRS (17'(FP)),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .Clock (Clock),
      .Reset (Reset),
      .Start (Start),
      .Stop  (stop),
      .bus   (bus)
`ifdef RGB_WR_STATS_EN
      ,
      .stall_cycles    (stall),
      .underrun_cycles (underrun)
`endif
   );

   rgb_sram_writer #(
      .RGB_START   (START_E),
      .FRAME_PAIRS (17'(FP)),
      .FIFO_DEPTH  (DEPTH)
   ) dut_e (
      .Clock (Clock),
      .Reset (Reset),
      .Start (Start),
      .Stop  (stop_e),
      .bus   (bus_e)
`ifdef RGB_WR_STATS_EN
      ,
      .stall_cycles    (stall_e),
      .underrun_cycles (underrun_e)
`endif
   );

   always #5 Clock = ~Clock;

   int          n_checks = 0;
   int          n_errors = 0;
   vec_t        tbl [8];
   logic [17:0] wr_addr [$];
   logic [15:0] wr_data [$];
   int          e_cnt = 0;
   logic [17:0] e_last = '0;

   // Write log, sampled well after the edge that updates the registered SRAM pins.
   always @(posedge Clock) begin
      #2;
      if (bus.SRAM_we_n == 1'b0) begin
         wr_addr.push_back(bus.SRAM_address);
         wr_data.push_back(bus.SRAM_write_data);
      end
      if (bus_e.SRAM_we_n == 1'b0) begin
         e_cnt++;
         e_last = bus_e.SRAM_address;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_writes(input int base, input int n, input int budget, input string name);
      int c = 0;
      while ((wr_addr.size() - base) < n && c < budget) begin
         @(negedge Clock);
         c++;
      end
      chk(name, 32'(wr_addr.size() - base), 32'(n));
   endtask

   function automatic logic [15:0] tw(input int i, input int k);
      case (k)
         0:       return tbl[i].w0;
         1:       return tbl[i].w1;
         default: return tbl[i].w2;
      endcase
   endfunction

   function automatic logic [7:0] fbyte(input int i, input int b);
      logic [7:0] v [6];
      v[0] = 8'(i);
      v[1] = 8'(i * 3 + 1);
      v[2] = 8'(255 - i);
      v[3] = 8'(i + 100);
      v[4] = 8'(i * 7);
      v[5] = 8'hC3;
      return v[b];
   endfunction

   function automatic logic [47:0] frame_pix(input int i);
      return {fbyte(i, 0), fbyte(i, 1), fbyte(i, 2), fbyte(i, 3), fbyte(i, 4), fbyte(i, 5)};
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, %0d errors so far", n_errors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int   idx, base, e_base;
      logic take;
      logic [15:0] t1_w [3];

      tbl[0] = '{48'h112233445566, 16'h1122, 16'h3344, 16'h5566};
      tbl[1] = '{48'h000000000000, 16'h0000, 16'h0000, 16'h0000};
      tbl[2] = '{48'hFFFFFFFFFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
      tbl[3] = '{48'h80017FFE00FF, 16'h8001, 16'h7FFE, 16'h00FF};
      tbl[4] = '{48'hDEADBEEFCAFE, 16'hDEAD, 16'hBEEF, 16'hCAFE};
      tbl[5] = '{48'h0123456789AB, 16'h0123, 16'h4567, 16'h89AB};
      tbl[6] = '{48'hA55AC33C0FF0, 16'hA55A, 16'hC33C, 16'h0FF0};
      tbl[7] = '{48'h123456789ABC, 16'h1234, 16'h5678, 16'h9ABC};
      t1_w[0] = 16'h0A14;
      t1_w[1] = 16'h1E28;
      t1_w[2] = 16'h323C;

      Reset = 1'b1;
      Start = 1'b0;
      bus.pix_valid  = 1'b0;
      bus.pix_data   = '0;
      bus.sram_grant = 1'b0;
      repeat (3) @(negedge Clock);
      chk("rst_stop", 32'(stop), 0);
      chk("rst_ready", 32'(bus.pix_ready), 0);
      chk("rst_req", 32'(bus.sram_req), 0);
      chk("rst_addr", 32'(bus.SRAM_address), 0);
      chk("rst_data", 32'(bus.SRAM_write_data), 0);
      chk("rst_we_n", 32'(bus.SRAM_we_n), 1);
      Reset = 1'b0;
      @(negedge Clock);
      chk("idle_ready", 32'(bus.pix_ready), 0);

      // Single pair with grant held: three consecutive writes one edge after acceptance.
      Start = 1'b1;
      @(negedge Clock);
      Start = 1'b0;
      chk("t1_ready", 32'(bus.pix_ready), 1);
      bus.pix_valid  = 1'b1;
      bus.pix_data   = 48'h0A141E28323C;
      bus.sram_grant = 1'b1;
      @(negedge Clock);
      bus.pix_valid = 1'b0;
      chk("t1_no_write_yet", 32'(bus.SRAM_we_n), 1);
      chk("t1_req", 32'(bus.sram_req), 1);
      for (int k = 0; k < 3; k++) begin
         @(negedge Clock);
         chk("t1_we_n", 32'(bus.SRAM_we_n), 0);
         chk("t1_addr", 32'(bus.SRAM_address), 32'(START_A) + 32'(k));
         chk("t1_data", 32'(bus.SRAM_write_data), 32'(t1_w[k]));
      end
      @(negedge Clock);
      chk("t1_we_n_after", 32'(bus.SRAM_we_n), 1);
      chk("t1_req_after", 32'(bus.sram_req), 0);

      // Grant dropped for five cycles after word 0.
      bus.pix_valid = 1'b1;
      bus.pix_data  = 48'h010203040506;
      @(negedge Clock);
      bus.pix_valid = 1'b0;
      @(negedge Clock);
      chk("t2_w0_addr", 32'(bus.SRAM_address), 32'(START_A) + 3);
      chk("t2_w0_data", 32'(bus.SRAM_write_data), 32'h0102);
      bus.sram_grant = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge Clock);
         chk("t2_gap_we_n", 32'(bus.SRAM_we_n), 1);
         chk("t2_gap_req", 32'(bus.sram_req), 1);
      end
      chk("t2_gap_addr_hold", 32'(bus.SRAM_address), 32'(START_A) + 3);
      bus.sram_grant = 1'b1;
      @(negedge Clock);
      chk("t2_w1_addr", 32'(bus.SRAM_address), 32'(START_A) + 4);
      chk("t2_w1_data", 32'(bus.SRAM_write_data), 32'h0304);
      @(negedge Clock);
      chk("t2_w2_addr", 32'(bus.SRAM_address), 32'(START_A) + 5);
      chk("t2_w2_data", 32'(bus.SRAM_write_data), 32'h0506);
      @(negedge Clock);
      chk("t2_we_n_after", 32'(bus.SRAM_we_n), 1);

      // Table stream: backpressure with grant off, then drain in order.
      base = wr_addr.size();
      bus.sram_grant = 1'b0;
      idx = 0;
      for (int c = 0; c < 20; c++) begin
         bus.pix_valid = 1'b1;
         bus.pix_data  = tbl[idx].pix;
         take = bus.pix_ready;
         @(negedge Clock);
         if (take) idx++;
      end
      chk("t3_accepted_blocked", 32'(idx), 32'(DEPTH));
      chk("t3_ready_low", 32'(bus.pix_ready), 0);
      chk("t3_no_writes", 32'(wr_addr.size() - base), 0);
      bus.sram_grant = 1'b1;
      for (int c = 0; c < 100 && idx < 8; c++) begin
         bus.pix_valid = 1'b1;
         bus.pix_data  = tbl[idx].pix;
         take = bus.pix_ready;
         @(negedge Clock);
         if (take) idx++;
      end
      bus.pix_valid = 1'b0;
      wait_writes(base, 24, 100, "t3_drain_count");
      for (int i = 0; i < 8; i++) begin
         for (int k = 0; k < 3; k++) begin
            if (base + 3 * i + k < wr_addr.size()) begin
               chk("t3_addr", 32'(wr_addr[base + 3 * i + k]), 32'(START_A) + 32'(3 * (2 + i) + k));
               chk("t3_data", 32'(wr_data[base + 3 * i + k]), 32'(tw(i, k)));
            end
         end
      end

      // Reset asserted just after word 0 of a pair.
      bus.pix_valid = 1'b1;
      bus.pix_data  = tbl[4].pix;
      @(negedge Clock);
      bus.pix_valid = 1'b0;
      @(negedge Clock);
      chk("t5_mid_pair_we_n", 32'(bus.SRAM_we_n), 0);
      Reset = 1'b1;
      @(negedge Clock);
      chk("t5_we_n", 32'(bus.SRAM_we_n), 1);
      chk("t5_stop", 32'(stop), 0);
      chk("t5_ready", 32'(bus.pix_ready), 0);
      chk("t5_req", 32'(bus.sram_req), 0);
      chk("t5_addr", 32'(bus.SRAM_address), 0);
      Reset = 1'b0;
      @(negedge Clock);
      Start = 1'b1;
      @(negedge Clock);
      Start = 1'b0;
      base = wr_addr.size();
      for (int c = 0; c < 3; c++) begin
         @(negedge Clock);
         chk("t5_fifo_empty_req", 32'(bus.sram_req), 0);
      end
      chk("t5_abandoned_pair", 32'(wr_addr.size() - base), 0);

      // Seven grant-off cycles with a pair pending.
      bus.sram_grant = 1'b0;
      bus.pix_valid  = 1'b1;
      bus.pix_data   = tbl[5].pix;
      @(negedge Clock);
      bus.pix_valid = 1'b0;
      repeat (7) @(negedge Clock);
      chk("t6_no_write", 32'(wr_addr.size() - base), 0);
`ifdef RGB_WR_STATS_EN
      chk("t6_stall", 32'(stall), 7);
      chk("t6_underrun", 32'(underrun), 4);
      chk("t6_stall_e", 32'(stall_e), 7);
      chk("t6_underrun_e", 32'(underrun_e), 4);
`endif
      bus.sram_grant = 1'b1;
      wait_writes(base, 3, 20, "t6_drain_count");
      if (wr_addr.size() > base) begin
         chk("t6_first_addr", 32'(wr_addr[base]), 32'(START_A));
         chk("t6_first_data", 32'(wr_data[base]), 32'(tbl[5].w0));
      end

      // Whole (shortened) frame with random valid/grant, then restart.
      Reset = 1'b1;
      @(negedge Clock);
      Reset = 1'b0;
      Start = 1'b1;
      @(negedge Clock);
      Start = 1'b0;
      base   = wr_addr.size();
      e_base = e_cnt;
      idx    = 0;
      for (int c = 0; c < 3000 && !stop; c++) begin
         bus.pix_valid  = (idx < FP) ? 1'($urandom_range(0, 1)) : 1'b0;
         bus.pix_data   = frame_pix(idx);
         bus.sram_grant = ($urandom_range(0, 3) != 0);
         take = bus.pix_valid & bus.pix_ready;
         @(negedge Clock);
         if (take) idx++;
      end
      bus.pix_valid = 1'b0;
      chk("t4_stop", 32'(stop), 1);
      chk("t4_pairs", 32'(idx), 32'(FP));
      chk("t4_writes", 32'(wr_addr.size() - base), 32'(3 * FP));
      for (int j = 0; j < 3 * FP && base + j < wr_addr.size(); j++) begin
         chk("t4_addr", 32'(wr_addr[base + j]), 32'(START_A) + 32'(j));
         chk("t4_data", 32'(wr_data[base + j]),
             32'({fbyte(j / 3, 2 * (j % 3)), fbyte(j / 3, 2 * (j % 3) + 1)}));
      end
      chk("t4_req_done", 32'(bus.sram_req), 0);
      chk("t4_e_writes", 32'(e_cnt - e_base), 32'(3 * FP));
      chk("t4_e_last_addr", 32'(e_last), 32'h3FFFF);
      chk("t4_e_stop", 32'(stop_e), 1);
      @(negedge Clock);
      chk("t4_done_we_n", 32'(bus.SRAM_we_n), 1);
      chk("t4_done_ready", 32'(bus.pix_ready), 0);

      Start = 1'b1;
      @(negedge Clock);
      Start = 1'b0;
      chk("t4_restart_stop", 32'(stop), 0);
      base = wr_addr.size();
      bus.pix_valid  = 1'b1;
      bus.pix_data   = tbl[4].pix;
      bus.sram_grant = 1'b1;
      @(negedge Clock);
      bus.pix_valid = 1'b0;
      wait_writes(base, 1, 20, "t4_restart_write");
      if (wr_addr.size() > base) begin
         chk("t4_restart_addr", 32'(wr_addr[base]), 32'(START_A));
         chk("t4_restart_data", 32'(wr_data[base]), 32'(tbl[4].w0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
